processor_core: RTL and testbench
=================================

// Module: processor_core
// PURPOSE
//   Single-cycle 32-bit datapath: decodes the externally supplied instruction word,
//   reads two registers, runs the ALU, accesses data memory and writes back, all in one clock.
//   Top-level compute block; instruction fetch is external.
//   WD exposes the write-data bus and isZero exposes the ALU zero flag, for observation.
// PARAMETERS
//   DATA_W    32  datapath / register / memory word width
//   REG_N     32  register-file entries (5-bit index)
//   MEM_DEPTH 64  data-memory words (index = address[7:2])
// PORTS
//   clk     input   1   single clock; all state updates on rising edge
//   reset   input   1   asynchronous, active-low reset (0 = in reset)
//   Inst    input   32  current instruction, held by driver for the cycle
//   isZero  output  1   1 when ALU result == 0
//   WD      output  32  write-data bus value for current instruction
// BEHAVIOUR
//   Decode fields:
//     op = Inst[31:26], rs = Inst[25:21], rt = Inst[20:16]
//     rd = Inst[15:11], imm = Inst[15:0]; Inst[10:0] ignored for R-type
//   Opcodes:
//     R-type, result to rd: 1 ADD rs+rt, 3 SUB rs-rt, 5 AND rs&rt, 6 OR rs|rt
//     2 LW : rt <= mem[(rs+sext(imm))[7:2]]
//     4 SW : mem[(rs+sext(imm))[7:2]] <= rt
//   Arithmetic: ADD/SUB are 32-bit modulo, wrap silently, no overflow flag.
//     Address = rs + sign-extended imm; bits [1:0] and [31:8] ignored (index wraps mod 64).
//   Outputs are combinational from Inst and current state (zero latency):
//     isZero = (ALU result == 0); for LW/SW the ALU result is the address sum.
//     WD = ALU result (R-type), loaded word (LW), rt store data (SW).
//     Undefined opcode: ALU result 0, WD = 0, isZero = 1, no state change.
//   Writeback on rising clk edge when reset = 1: R-type writes rd, LW writes rt, SW writes memory.
//     r0 is hardwired 0: writes to r0 are discarded and WD still shows the value.
//     A read of the register written this cycle returns the old value; the new value is visible next cycle.
//   Reset (reset = 0, async, any time incl. mid-cycle):
//     register i <= i (r0 = 0), mem[i] <= 32'h100 + i
//     WD forced to 0, isZero forced to 0, no writes while held
//     State and outputs resume on the first rising edge after release.
// TESTING
//   reset pulse low then high; ADD r1,r2,r3 (32'h04430820) -> WD=5, isZero=0; next cycle r1 reads 5
//   SUB r1,r2,r3 (op 3) -> WD=32'hFFFF_FFFF, isZero=0; SUB r1,r2,r2 -> WD=0, isZero=1
//   AND r1,r2,r3 (op 5) -> WD=2; OR r1,r2,r3 (op 6) -> WD=3; dest r0 -> r0 still reads 0
//   LW r1,0(r2) -> addr 2, index 0, WD=32'h100; LW r1,4(r2) -> WD=32'h101
//   SW r1,8(r0) with r1=5 -> WD=5; then LW r4,8(r0) -> WD=5; undefined op 7 -> WD=0, isZero=1
//   assert reset mid-test -> WD=0, isZero=0 immediately; registers/memory back to init values

Source files
------------

// File: rtl/processor_core.sv
// rtl/processor_core.sv - single-cycle 32-bit datapath: decode, register read, ALU, data memory, writeback
module processor_core #(
    parameter int DATA_W    = 32,
    parameter int REG_N     = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Inst,
    output logic              isZero,
    output logic [DATA_W-1:0] WD
);

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_LW  = 6'd2;
    localparam logic [5:0] OP_SUB = 6'd3;
    localparam logic [5:0] OP_SW  = 6'd4;
    localparam logic [5:0] OP_AND = 6'd5;
    localparam logic [5:0] OP_OR  = 6'd6;

    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] mem  [MEM_DEPTH];

    // Low after reset until the first rising edge following release.
    logic              run;

    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] wd_raw;
    logic [5:0]        mem_idx;
    logic              is_rtype;
    logic              reg_we;
    logic              mem_we;
    logic [4:0]        reg_waddr;

    assign op       = Inst[31:26];
    assign rs       = Inst[25:21];
    assign rt       = Inst[20:16];
    assign rd       = Inst[15:11];
    assign imm      = Inst[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};

    // r0 always reads zero regardless of what the storage holds.
    assign rs_val = (rs == 5'd0) ? '0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? '0 : regs[rt];

    assign is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:       alu_result = rs_val + rt_val;
            OP_SUB:       alu_result = rs_val - rt_val;
            OP_AND:       alu_result = rs_val & rt_val;
            OP_OR:        alu_result = rs_val | rt_val;
            OP_LW, OP_SW: alu_result = rs_val + imm_sext;
            default:      alu_result = '0;
        endcase
    end

    assign mem_idx = alu_result[7:2];

    always_comb begin
        wd_raw = '0;
        if (is_rtype) begin
            wd_raw = alu_result;
        end else if (op == OP_LW) begin
            wd_raw = mem[mem_idx];
        end else if (op == OP_SW) begin
            wd_raw = rt_val;
        end
    end

    assign WD     = (reset && run) ? wd_raw : '0;
    assign isZero = (reset && run) ? (alu_result == '0) : 1'b0;

    assign reg_waddr = is_rtype ? rd : rt;
    assign reg_we    = run && (is_rtype || (op == OP_LW)) && (reg_waddr != 5'd0);
    assign mem_we    = run && (op == OP_SW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= DATA_W'(i);
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= DATA_W'(32'h100 + i);
            end
        end else begin
            run <= 1'b1;
            if (reg_we) begin
                regs[reg_waddr] <= wd_raw;
            end
            if (mem_we) begin
                mem[mem_idx] <= rt_val;
            end
        end
    end

endmodule

// File: tb/tb_processor_core.sv
// tb/tb_processor_core.sv - directed self-checking bench for processor_core
module tb_processor_core;

    logic        clk;
    logic        reset;
    logic [31:0] Inst;
    logic        isZero;
    logic [31:0] WD;

    int tests_run;
    int tests_failed;

    processor_core dut (
        .clk    (clk),
        .reset  (reset),
        .Inst   (Inst),
        .isZero (isZero),
        .WD     (WD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] UNDEF = 32'h1C00_0000;

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Present an instruction mid-cycle; it commits on the following rising edge.
    task automatic apply(input logic [31:0] ins);
        @(negedge clk);
        Inst = ins;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Inst  = 32'h0443_0820;
        #1;
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL reset_wd: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL reset_zero: got %b expected %b", isZero, 1'b0); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        Inst  = UNDEF;
        #1;
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL release_wd: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL release_zero: got %b expected %b", isZero, 1'b0); end
        apply(UNDEF);
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL undef_wd: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b1) begin tests_failed++; $display("FAIL undef_zero: got %b expected %b", isZero, 1'b1); end
    endtask

    task automatic test_add;
        apply(32'h0443_0820);
        tests_run++; if (WD !== 32'd5) begin tests_failed++; $display("FAIL add_wd: got %h expected %h", WD, 32'd5); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL add_zero: got %b expected %b", isZero, 1'b0); end
        apply(rtype(6'd1, 5'd1, 5'd0, 5'd5));
        tests_run++; if (WD !== 32'd5) begin tests_failed++; $display("FAIL add_r1_next: got %h expected %h", WD, 32'd5); end
        apply(rtype(6'd1, 5'd1, 5'd1, 5'd1));
        tests_run++; if (WD !== 32'd10) begin tests_failed++; $display("FAIL add_self: got %h expected %h", WD, 32'd10); end
        apply(rtype(6'd1, 5'd1, 5'd0, 5'd6));
        tests_run++; if (WD !== 32'd10) begin tests_failed++; $display("FAIL add_self_next: got %h expected %h", WD, 32'd10); end
        apply(rtype(6'd1, 5'd31, 5'd31, 5'd14));
        tests_run++; if (WD !== 32'd62) begin tests_failed++; $display("FAIL add_r31: got %h expected %h", WD, 32'd62); end
    endtask

    task automatic test_sub;
        apply(rtype(6'd3, 5'd2, 5'd3, 5'd7));
        tests_run++; if (WD !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sub_wd: got %h expected %h", WD, 32'hFFFF_FFFF); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL sub_zero: got %b expected %b", isZero, 1'b0); end
        apply(rtype(6'd1, 5'd7, 5'd3, 5'd15));
        tests_run++; if (WD !== 32'd2) begin tests_failed++; $display("FAIL add_wrap: got %h expected %h", WD, 32'd2); end
        apply(rtype(6'd3, 5'd2, 5'd2, 5'd7));
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL sub_eq_wd: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b1) begin tests_failed++; $display("FAIL sub_eq_zero: got %b expected %b", isZero, 1'b1); end
    endtask

    task automatic test_logic;
        apply(rtype(6'd5, 5'd2, 5'd3, 5'd8));
        tests_run++; if (WD !== 32'd2) begin tests_failed++; $display("FAIL and_wd: got %h expected %h", WD, 32'd2); end
        apply(rtype(6'd6, 5'd2, 5'd3, 5'd8));
        tests_run++; if (WD !== 32'd3) begin tests_failed++; $display("FAIL or_wd: got %h expected %h", WD, 32'd3); end
        apply(rtype(6'd5, 5'd4, 5'd3, 5'd16));
        tests_run++; if (isZero !== 1'b1) begin tests_failed++; $display("FAIL and_zero: got %b expected %b", isZero, 1'b1); end
    endtask

    task automatic test_r0;
        apply(rtype(6'd1, 5'd2, 5'd3, 5'd0));
        tests_run++; if (WD !== 32'd5) begin tests_failed++; $display("FAIL r0_dest_wd: got %h expected %h", WD, 32'd5); end
        apply(rtype(6'd1, 5'd0, 5'd0, 5'd9));
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL r0_read: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b1) begin tests_failed++; $display("FAIL r0_zero: got %b expected %b", isZero, 1'b1); end
    endtask

    task automatic test_mem;
        apply(itype(6'd2, 5'd2, 5'd10, 16'd0));
        tests_run++; if (WD !== 32'h100) begin tests_failed++; $display("FAIL lw0_wd: got %h expected %h", WD, 32'h100); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL lw0_zero: got %b expected %b", isZero, 1'b0); end
        apply(itype(6'd2, 5'd2, 5'd10, 16'd4));
        tests_run++; if (WD !== 32'h101) begin tests_failed++; $display("FAIL lw4_wd: got %h expected %h", WD, 32'h101); end
        apply(rtype(6'd1, 5'd10, 5'd0, 5'd11));
        tests_run++; if (WD !== 32'h101) begin tests_failed++; $display("FAIL lw_wb: got %h expected %h", WD, 32'h101); end
        apply(itype(6'd4, 5'd0, 5'd5, 16'd8));
        tests_run++; if (WD !== 32'd5) begin tests_failed++; $display("FAIL sw_wd: got %h expected %h", WD, 32'd5); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL sw_zero: got %b expected %b", isZero, 1'b0); end
        apply(itype(6'd2, 5'd0, 5'd4, 16'd8));
        tests_run++; if (WD !== 32'd5) begin tests_failed++; $display("FAIL sw_lw: got %h expected %h", WD, 32'd5); end
        apply(itype(6'd2, 5'd0, 5'd12, 16'hFFFC));
        tests_run++; if (WD !== 32'h13F) begin tests_failed++; $display("FAIL lw_wrap: got %h expected %h", WD, 32'h13F); end
        apply(itype(6'd2, 5'd2, 5'd12, 16'hFFFE));
        tests_run++; if (WD !== 32'h100) begin tests_failed++; $display("FAIL lw_neg_wd: got %h expected %h", WD, 32'h100); end
        tests_run++; if (isZero !== 1'b1) begin tests_failed++; $display("FAIL lw_neg_zero: got %b expected %b", isZero, 1'b1); end
    endtask

    task automatic test_mid_reset;
        apply(rtype(6'd1, 5'd2, 5'd3, 5'd1));
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        tests_run++; if (WD !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_wd: got %h expected %h", WD, 32'd0); end
        tests_run++; if (isZero !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_zero: got %b expected %b", isZero, 1'b0); end
        @(negedge clk);
        reset = 1'b1;
        Inst  = UNDEF;
        apply(rtype(6'd1, 5'd1, 5'd0, 5'd13));
        tests_run++; if (WD !== 32'd1) begin tests_failed++; $display("FAIL mid_reset_r1: got %h expected %h", WD, 32'd1); end
        apply(rtype(6'd1, 5'd10, 5'd0, 5'd13));
        tests_run++; if (WD !== 32'd10) begin tests_failed++; $display("FAIL mid_reset_r10: got %h expected %h", WD, 32'd10); end
        apply(itype(6'd2, 5'd0, 5'd12, 16'd8));
        tests_run++; if (WD !== 32'h102) begin tests_failed++; $display("FAIL mid_reset_mem: got %h expected %h", WD, 32'h102); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        Inst         = UNDEF;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_r0();
        test_mem();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
